// File: rtl/prison_box_reader_if.sv
// Box storage read port: the reader drives strobe/address, storage returns data one cycle later.
interface prison_box_reader_if #(
    parameter int unsigned IDX_W = 8
) ();
    logic             box_rd_en;
    logic [IDX_W-1:0] box_rd_addr;
    logic [IDX_W-1:0] box_rd_data;

    modport master (
        output box_rd_en,
        output box_rd_addr,
        input  box_rd_data
    );

    modport slave (
        input  box_rd_en,
        input  box_rd_addr,
        output box_rd_data
    );
endinterface

// File: rtl/prison_box_reader.sv
// Loop-following read engine: each prisoner starts at its own box and chases values until it
// finds its own number, runs out of opens, or reads an illegal value.
module prison_box_reader #(
    parameter int unsigned N_PRISONERS = 100,
    parameter int unsigned MAX_OPENS   = 50,
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    prison_box_reader_if.master     box,
    output logic                    busy,
    output logic                    done,
    output logic                    win,
    output logic                    err,
    output logic [IDX_W-1:0]        fail_prisoner,
    output logic [CNT_W-1:0]        total_opens
);
    localparam int unsigned         OPEN_W   = $clog2(MAX_OPENS + 1);
    localparam logic [IDX_W-1:0]    LastIdx  = IDX_W'(N_PRISONERS);
    localparam logic [OPEN_W-1:0]   MaxOpens = OPEN_W'(MAX_OPENS);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [OPEN_W-1:0]   opens_q, opens_d;
    logic                win_q, win_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    fail_q, fail_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [IDX_W-1:0]    rd_data;

    assign rd_data = box.box_rd_data;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cur_d   = cur_q;
        opens_d = opens_q;
        win_d   = win_q;
        err_d   = err_q;
        fail_d  = fail_q;
        total_d = total_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StIssue;
                    win_d   = 1'b0;
                    err_d   = 1'b0;
                    fail_d  = '0;
                    total_d = '0;
                    cur_d   = IDX_W'(1);
                    addr_d  = '0;
                    opens_d = '0;
                end
            end
            StIssue: begin
                opens_d = opens_q + OPEN_W'(1);
                total_d = total_q + CNT_W'(1);
                state_d = StWait;
            end
            StWait: begin
                if (rd_data == '0 || rd_data > LastIdx) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (rd_data == cur_q) begin
                    if (cur_q == LastIdx) begin
                        win_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        // Next prisoner starts at its own box, whose address equals cur_q.
                        cur_d   = cur_q + IDX_W'(1);
                        addr_d  = cur_q;
                        opens_d = '0;
                        state_d = StIssue;
                    end
                end else if (opens_q == MaxOpens) begin
                    fail_d  = cur_q;
                    state_d = StDone;
                end else begin
                    addr_d  = rd_data - IDX_W'(1);
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cur_q   <= '0;
            opens_q <= '0;
            win_q   <= 1'b0;
            err_q   <= 1'b0;
            fail_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cur_q   <= cur_d;
            opens_q <= opens_d;
            win_q   <= win_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            total_q <= total_d;
        end
    end

    assign box.box_rd_en   = (state_q == StIssue);
    assign box.box_rd_addr = addr_q;
    assign busy            = (state_q == StIssue) || (state_q == StWait);
    assign done            = (state_q == StDone);
    assign win             = win_q;
    assign err             = err_q;
    assign fail_prisoner   = fail_q;
    assign total_opens     = total_q;
endmodule

// File: tb/tb_prison_box_reader.sv
// Directed bench for prison_box_reader: scoreboard of expected results popped on each done pulse.
module tb_prison_box_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        busy, done, win, err;
    logic [7:0]  fail_prisoner;
    logic [15:0] total_opens;
    logic [7:0]  mem [0:99];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        win;
        logic        err;
        logic [7:0]  fail;
        logic [15:0] total;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    prison_box_reader_if #(.IDX_W(8)) box_if ();

    prison_box_reader #(
        .N_PRISONERS(100),
        .MAX_OPENS  (50),
        .IDX_W      (8),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .box          (box_if),
        .busy         (busy),
        .done         (done),
        .win          (win),
        .err          (err),
        .fail_prisoner(fail_prisoner),
        .total_opens  (total_opens)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Box storage model: registered read, data valid the cycle after the strobe.
    initial box_if.box_rd_data = '0;
    always @(posedge clk) begin
        if (box_if.box_rd_en) box_if.box_rd_data <= mem[box_if.box_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("win", {31'd0, win}, {31'd0, e.win});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("fail_prisoner", {24'd0, fail_prisoner}, {24'd0, e.fail});
                chk("total_opens", {16'd0, total_opens}, {16'd0, e.total});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // 0 identity, 1 single 100-cycle, 2 two 50-cycles, 3 identity with box 3 = 0.
    task automatic load_table(input int mode);
        for (int i = 1; i <= 100; i++) begin
            case (mode)
                1:       mem[i-1] = (i == 100) ? 8'd1 : 8'(i + 1);
                2:       if (i <= 50) mem[i-1] = 8'((i % 50) + 1);
                         else mem[i-1] = (i == 100) ? 8'd51 : 8'(i + 1);
                default: mem[i-1] = 8'(i);
            endcase
        end
        if (mode == 3) mem[2] = 8'd0;
    endtask

    task automatic start_run(input logic push, input logic w, input logic e,
                             input logic [7:0] f, input logic [15:0] t, input int lat);
        exp_t x;
        @(posedge clk);
        #1;
        run = 1'b1;
        x.win = w; x.err = e; x.fail = f; x.total = t; x.done_cyc = cyc + lat;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required=0 pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int start;
        load_table(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_win", {31'd0, win}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd_en", {31'd0, box_if.box_rd_en}, 32'd0);
        chk("rst_rd_addr", {24'd0, box_if.box_rd_addr}, 32'd0);
        chk("rst_total", {16'd0, total_opens}, 32'd0);

        // Identity table: every prisoner wins on first open.
        start_run(1'b1, 1'b1, 1'b0, 8'd0, 16'd100, 201);
        wait_empty(400);
        repeat (5) @(posedge clk);
        #1;
        chk("win_held", {31'd0, win}, 32'd1);
        chk("total_held", {16'd0, total_opens}, 32'd100);

        // Single 100-cycle: prisoner 1 fails; also watch the address sequence.
        load_table(1);
        @(posedge clk);
        #1;
        run = 1'b1;
        start = cyc;
        sb.push_back('{win: 1'b0, err: 1'b0, fail: 8'd1, total: 16'd50, done_cyc: start + 101});
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) run = 1'b0;
            chk("rd_en_seq", {31'd0, box_if.box_rd_en}, {31'd0, k[0]});
            chk("rd_addr_seq", {24'd0, box_if.box_rd_addr}, 32'((k - 1) / 2));
        end
        wait_empty(50);

        // Two 50-cycles: everyone matches exactly on the last allowed open.
        load_table(2);
        start_run(1'b1, 1'b1, 1'b0, 8'd0, 16'd5000, 10001);
        wait_empty(10100);

        // Illegal content in box 3.
        load_table(3);
        start_run(1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 7);
        wait_empty(50);

        // Run re-pulsed while busy is ignored.
        load_table(0);
        start_run(1'b1, 1'b1, 1'b0, 8'd0, 16'd100, 201);
        repeat (20) @(posedge clk);
        #1;
        run = 1'b1;
        chk("busy_mid_run", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        run = 1'b0;
        wait_empty(400);
        repeat (20) @(posedge clk);

        // Reset mid-run aborts with no done pulse.
        start_run(1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 0);
        repeat (38) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_win", {31'd0, win}, 32'd0);
        chk("abort_total", {16'd0, total_opens}, 32'd0);
        chk("abort_rd_en", {31'd0, box_if.box_rd_en}, 32'd0);
        chk("abort_rd_addr", {24'd0, box_if.box_rd_addr}, 32'd0);
        repeat (250) @(posedge clk);

        start_run(1'b1, 1'b1, 1'b0, 8'd0, 16'd100, 201);
        wait_empty(400);
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
